// File: rtl/gpio_ctrl_if.sv
// Wishbone classic bus bundle for gpio_ctrl.
// The master drives the cycle/strobe/address/data; the slave returns ack and read data.
interface gpio_ctrl_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_ack;
  logic [31:0] wb_dat_r;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    input  wb_ack, wb_dat_r
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    output wb_ack, wb_dat_r
  );
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: OUT/OE/IN/edge-IRQ registers behind a Wishbone classic slave.
// Optional macro GPIO_DEBOUNCE_EN inserts a per-pin debounce filter after the synchronizer.
module gpio_ctrl #(
  parameter int NUM_IO          = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  gpio_ctrl_if.slave        wb,
  input  logic [NUM_IO-1:0] gpio_i,
  output logic [NUM_IO-1:0] gpio_o,
  output logic [NUM_IO-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [2:0] ADR_OUT     = 3'd0;
  localparam logic [2:0] ADR_OE      = 3'd1;
  localparam logic [2:0] ADR_IN      = 3'd2;
  localparam logic [2:0] ADR_RISE_IE = 3'd3;
  localparam logic [2:0] ADR_FALL_IE = 3'd4;
  localparam logic [2:0] ADR_PEND    = 3'd5;

  if ((NUM_IO < 1) || (NUM_IO > 32) || (DEBOUNCE_CYCLES < 2)) begin : g_param_check
    $error("gpio_ctrl: NUM_IO must be 1..32 and DEBOUNCE_CYCLES at least 2");
  end

  logic [NUM_IO-1:0] r_out, r_oe, r_rise_ie, r_fall_ie, r_pend;
  logic [NUM_IO-1:0] r_sync1, r_sync2, r_prev;
  logic              r_ack, r_irq;
  logic [31:0]       r_dat_r;

  logic              w_req, w_wr;
  logic [31:0]       w_lane_mask, w_wdat_full, w_rdat;
  logic              w_unused_hi;
  logic [NUM_IO-1:0] w_wdat, w_mask, w_in, w_pend_set, w_pend_clr, w_out_nxt;

  function automatic logic [NUM_IO-1:0] f_merge(input logic [NUM_IO-1:0] old_v,
                                                input logic [NUM_IO-1:0] new_v,
                                                input logic [NUM_IO-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // The ack itself blocks a new request, giving the mandatory idle cycle between acks.
  assign w_req       = wb.wb_cyc & wb.wb_stb & ~r_ack;
  assign w_wr        = w_req & wb.wb_we;
  assign w_lane_mask = {{8{wb.wb_sel[3]}}, {8{wb.wb_sel[2]}}, {8{wb.wb_sel[1]}}, {8{wb.wb_sel[0]}}};
  assign w_wdat_full = wb.wb_dat_w & w_lane_mask;
  assign w_wdat      = w_wdat_full[NUM_IO-1:0];
  assign w_mask      = w_lane_mask[NUM_IO-1:0];
  assign w_unused_hi = ^{w_wdat_full, w_lane_mask};

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0]     r_cnt [NUM_IO];
  logic [NUM_IO-1:0] r_deb;

  // Debounced value follows the synchronizer only after DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_deb <= '0;
      for (int i = 0; i < NUM_IO; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_in = r_deb;
`else
  assign w_in = r_sync2;
`endif

  assign w_pend_set = (w_in & ~r_prev & r_rise_ie) | (~w_in & r_prev & r_fall_ie);
  assign w_pend_clr = (w_wr && (wb.wb_adr == ADR_PEND)) ? w_wdat : '0;

  always_comb begin
    w_out_nxt = r_out;
    if (w_wr) begin
      case (wb.wb_adr)
        ADR_OUT: w_out_nxt = f_merge(r_out, w_wdat, w_mask);
        3'd6:    w_out_nxt = r_out | w_wdat;
        3'd7:    w_out_nxt = r_out & ~w_wdat;
        default: w_out_nxt = r_out;
      endcase
    end else begin
      w_out_nxt = r_out;
    end
  end

  always_comb begin
    w_rdat = 32'h0000_0000;
    case (wb.wb_adr)
      ADR_OUT:     w_rdat[NUM_IO-1:0] = r_out;
      ADR_OE:      w_rdat[NUM_IO-1:0] = r_oe;
      ADR_IN:      w_rdat[NUM_IO-1:0] = w_in;
      ADR_RISE_IE: w_rdat[NUM_IO-1:0] = r_rise_ie;
      ADR_FALL_IE: w_rdat[NUM_IO-1:0] = r_fall_ie;
      ADR_PEND:    w_rdat[NUM_IO-1:0] = r_pend;
      default:     w_rdat = 32'h0000_0000;
    endcase
  end

  // Bus response, register file, input synchronizers and interrupt state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ack     <= 1'b0;
      r_dat_r   <= 32'h0000_0000;
      r_out     <= '0;
      r_oe      <= '0;
      r_rise_ie <= '0;
      r_fall_ie <= '0;
      r_pend    <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_dat_r <= (w_req && !wb.wb_we) ? w_rdat : 32'h0000_0000;
      r_out   <= w_out_nxt;
      if (w_wr && (wb.wb_adr == ADR_OE))      r_oe      <= f_merge(r_oe, w_wdat, w_mask);
      if (w_wr && (wb.wb_adr == ADR_RISE_IE)) r_rise_ie <= f_merge(r_rise_ie, w_wdat, w_mask);
      if (w_wr && (wb.wb_adr == ADR_FALL_IE)) r_fall_ie <= f_merge(r_fall_ie, w_wdat, w_mask);
      r_pend  <= (r_pend & ~w_pend_clr) | w_pend_set;
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
      r_prev  <= w_in;
      r_irq   <= |r_pend;
    end
  end

  assign wb.wb_ack   = r_ack;
  assign wb.wb_dat_r = r_dat_r;
  assign gpio_o      = r_out;
  assign gpio_oe     = r_oe;
  assign irq         = r_irq;

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
SoC-side GPIO peripheral that sits behind the board's pad tristate logic. It drives the per-pin io*_o / io*_oe signals and samples io*_i back through synchronizers. It exposes output, direction, input and edge-interrupt registers over a Wishbone classic slave port, with a single level IRQ to the CPU.

Parameters:
NUM_IO, 20, number of GPIO pins; legal range 1..32
DEBOUNCE_CYCLES, 16, stable-input cycles required before the debounced value updates; used only with GPIO_DEBOUNCE_EN; minimum 2

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
wb_cyc  input  1  bus cycle valid
wb_stb  input  1  strobe
wb_we  input  1  1 = write
wb_adr  input  3  word address (byte address bits [4:2])
wb_dat_w  input  32  write data
wb_sel  input  4  byte-lane enables
wb_ack  output  1  transfer acknowledge
wb_dat_r  output  32  read data
gpio_i  input  NUM_IO  raw pad inputs (asynchronous)
gpio_o  output  NUM_IO  pad output values
gpio_oe  output  NUM_IO  pad output enables (1 = drive)
irq  output  1  level interrupt

Behaviour:
- One clock domain, sys_clk. Reset is asynchronous and active-low on sys_rst_n and clears every flop.
- Reset values: gpio_o=0, gpio_oe=0 (all pins inputs), wb_ack=0, wb_dat_r=0, irq=0, all registers 0, synchronizer flops 0.
- Register map (wb_adr):
  - 0 OUT (R/W)
  - 1 OE (R/W)
  - 2 IN (RO, synchronized input)
  - 3 RISE_IE (R/W)
  - 4 FALL_IE (R/W)
  - 5 PEND (R, write-1-to-clear)
  - 6 OUT_SET (W, OR into OUT; reads 0)
  - 7 OUT_CLR (W, AND-NOT into OUT; reads 0)
- Bits at positions >= NUM_IO read 0 and ignore writes.
- Bus handshake:
  - When wb_cyc & wb_stb & ~wb_ack, the block acks on the next cycle: wb_ack high exactly 1 cycle, then low for at least 1 cycle. Sustained strobe therefore gives one ack every 2 cycles.
  - Register write takes effect on the same edge that raises wb_ack.
  - wb_dat_r is valid while wb_ack is high and is 0 otherwise.
  - wb_sel gates writes per byte lane, including W1C, SET and CLR.
  - Reads have no side effects.
- Input path:
  - 2-flop synchronizer per pin; IN reflects gpio_i 2 cycles after a change (before reading).
  - sync_prev holds the previous synchronized value. Rise = sync & ~sync_prev; fall = ~sync & sync_prev.
  - Edge detection applies to all pins regardless of OE, so pins driven as outputs loop back.
- Interrupts:
  - PEND[i] is set on rise & RISE_IE[i] or fall & FALL_IE[i].
  - If a set and a W1C of the same bit land on the same cycle, the set wins.
  - Clearing an IE bit does not clear PEND.
  - irq = |PEND, registered; asserts 1 cycle after the PEND bit sets.
- gpio_o and gpio_oe are driven directly from the OUT and OE registers, 0 combinational delay after the register edge.
- Reset mid-transfer: ack is dropped immediately. The master must restart the cycle.

Optional Feature:
- GPIO_DEBOUNCE_EN defined:
  - A per-pin counter sits after the synchronizer. The debounced value takes the synchronized value only after it has differed from the current debounced value for DEBOUNCE_CYCLES consecutive cycles.
  - Any reversion before that resets the counter to 0.
  - IN and edge detection use the debounced value. Latency = 2 + DEBOUNCE_CYCLES cycles.
- Not defined: no counters. IN and edges use the synchronized value directly.

Test Plan:
- Reset then read every address -> all 0; gpio_oe=0, irq=0. Each read ack is exactly 1 cycle wide, 1 cycle after strobe.
- Write OUT=0x000A5, then OE=0x000FF with wb_sel=4'b0001 -> gpio_o=0x000A5, gpio_oe=0x000FF. Then OUT_SET=0x00100 -> OUT=0x001A5. Then OUT_CLR=0x00005 -> OUT=0x001A0.
- Write OUT=0xFFFFFFFF with NUM_IO=20 -> reads back 0x000FFFFF.
- RISE_IE=0x1, toggle gpio_i[0] 0->1 -> IN[0]=1 by cycle 2, PEND=0x1, irq high 1 cycle later. The falling edge does not set PEND. W1C 0x1 -> irq low.
- Same-cycle W1C of PEND[3] and a new qualified fall on pin 3 -> PEND[3] remains 1.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - a 10-cycle glitch on gpio_i[2] -> IN unchanged, no PEND;
  - a 20-cycle-wide pulse -> IN[2] rises 18 cycles after the pin edge.
